// File: rtl/code_status_engine_if.sv
// code_status_engine_if: code-beat input, payload output and status signals of the engine.
interface code_status_engine_if #(
  parameter int CH_NUM  = 4,
  parameter int CODE_W  = 8,
  parameter int PL_W    = 16,
  parameter int MAX_LEN = 4
);
  localparam int CH_W  = CH_NUM > 1 ? $clog2(CH_NUM) : 1;
  localparam int LEN_W = $clog2(MAX_LEN + 1);
  logic [CODE_W-1:0] match_code;
  logic              in_valid;
  logic              in_ready;
  logic [CH_W-1:0]   in_ch;
  logic [CODE_W-1:0] in_code;
  logic              out_valid;
  logic              out_ready;
  logic [CH_W-1:0]   out_ch;
  logic [PL_W-1:0]   out_pl;
  logic [LEN_W-1:0]  out_len;
  logic [CH_NUM-1:0] ch_busy;
  logic [15:0]       err_cnt;
  modport master (
    output match_code, in_valid, in_ch, in_code, out_ready,
    input  in_ready, out_valid, out_ch, out_pl, out_len, ch_busy, err_cnt
  );
  modport slave (
    input  match_code, in_valid, in_ch, in_code, out_ready,
    output in_ready, out_valid, out_ch, out_pl, out_len, ch_busy, err_cnt
  );
endinterface

// File: rtl/code_status_engine.sv
// code_status_engine: per-channel start/accumulate/emit packet engine with a round-robin payload output.
module code_status_engine #(
  parameter int CH_NUM  = 4,
  parameter int CODE_W  = 8,
  parameter int PL_W    = 16,
  parameter int MAX_LEN = 4
) (
  input logic                clock,
  input logic                rst_n,
  code_status_engine_if.slave bus
);
  localparam int CH_W  = CH_NUM > 1 ? $clog2(CH_NUM) : 1;
  localparam int LEN_W = $clog2(MAX_LEN + 1);
  typedef enum logic [1:0] {IDLE, ARMED, EMIT} state_t;
  state_t           st [CH_NUM];
  logic [PL_W-1:0]  pl [CH_NUM];
  logic [LEN_W-1:0] len [CH_NUM];
  logic [CH_W-1:0]  last_grant;
  logic [CH_W-1:0]  grant;
  logic             found;
  logic             load;
  logic             drop;
  logic             accept;
  // Out-of-range channels fall through the loop: ready, and always dropped.
  always_comb begin
    bus.in_ready = 1'b1;
    drop = 1'b1;
    for (int i = 0; i < CH_NUM; i++)
      if (bus.in_ch == CH_W'(i)) begin
        bus.in_ready = st[i] != EMIT;
        drop = st[i] == IDLE && bus.in_code != bus.match_code;
      end
  end
  assign accept = bus.in_valid & bus.in_ready;
  always_comb begin
    found = 1'b0;
    grant = '0;
    for (int k = 1; k <= CH_NUM; k++)
      if (!found && st[(int'(last_grant) + k) % CH_NUM] == EMIT) begin
        found = 1'b1;
        grant = CH_W'((int'(last_grant) + k) % CH_NUM);
      end
  end
  assign load = found & (!bus.out_valid | bus.out_ready);
  always_comb begin
    bus.ch_busy = '0;
    for (int i = 0; i < CH_NUM; i++) bus.ch_busy[i] = st[i] != IDLE;
  end
  always_ff @(posedge clock or negedge rst_n)
    if (!rst_n) begin
      for (int c = 0; c < CH_NUM; c++) begin
        st[c]  <= IDLE;
        pl[c]  <= '0;
        len[c] <= '0;
      end
    end else begin
      for (int c = 0; c < CH_NUM; c++)
        if (st[c] == EMIT) begin
          if (load && grant == CH_W'(c)) st[c] <= IDLE;
        end else if (accept && bus.in_ch == CH_W'(c)) begin
          if (st[c] == IDLE) begin
            if (bus.in_code == bus.match_code) begin
              st[c]  <= ARMED;
              pl[c]  <= '0;
              len[c] <= '0;
            end
          end else if (bus.in_code == '0) st[c] <= EMIT;
          else begin
            pl[c]  <= pl[c] + PL_W'(bus.in_code);
            len[c] <= len[c] + LEN_W'(1);
            if (len[c] == LEN_W'(MAX_LEN - 1)) st[c] <= EMIT;
          end
        end
    end
  // last_grant resets to the top channel so channel 0 wins the first arbitration.
  always_ff @(posedge clock or negedge rst_n)
    if (!rst_n) begin
      bus.out_valid <= 1'b0;
      bus.out_ch    <= '0;
      bus.out_pl    <= '0;
      bus.out_len   <= '0;
      last_grant    <= CH_W'(CH_NUM - 1);
      bus.err_cnt   <= '0;
    end else begin
      if (load) begin
        bus.out_valid <= 1'b1;
        bus.out_ch    <= grant;
        bus.out_pl    <= pl[grant];
        bus.out_len   <= len[grant];
        last_grant    <= grant;
      end else if (bus.out_ready) bus.out_valid <= 1'b0;
      if (accept && drop && bus.err_cnt != 16'hFFFF) bus.err_cnt <= bus.err_cnt + 16'd1;
    end
endmodule

// File: tb/tb_code_status_engine.sv
// tb_code_status_engine: directed scenarios plus a randomized run against a packet-level reference model.
module tb_code_status_engine;
  logic clock = 1'b0;
  logic rst_n = 1'b0;
  int errors = 0;
  int checks = 0;
  always #5 clock = ~clock;
  code_status_engine_if #(.CH_NUM(4), .CODE_W(8), .PL_W(16), .MAX_LEN(4)) bus ();
  code_status_engine_if #(.CH_NUM(4), .CODE_W(8), .PL_W(8), .MAX_LEN(4)) bus8 ();
  code_status_engine #(.CH_NUM(4), .CODE_W(8), .PL_W(16), .MAX_LEN(4)) dut (.clock(clock), .rst_n(rst_n), .bus(bus));
  code_status_engine #(.CH_NUM(4), .CODE_W(8), .PL_W(8), .MAX_LEN(4)) dut8 (.clock(clock), .rst_n(rst_n), .bus(bus8));
  int m_mode [4];
  int m_sum [4];
  int m_n [4];
  int m_ov, m_ch, m_pl, m_len, m_last, m_err;

  task automatic send(input int ch, input logic [7:0] code);
    bus.in_valid = 1'b1;
    bus.in_ch = 2'(ch);
    bus.in_code = code;
    @(negedge clock);
    bus.in_valid = 1'b0;
  endtask

  task automatic send8(input int ch, input logic [7:0] code);
    bus8.in_valid = 1'b1;
    bus8.in_ch = 2'(ch);
    bus8.in_code = code;
    @(negedge clock);
    bus8.in_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus8.in_valid = 1'b0;
    repeat (2) @(negedge clock);
    rst_n = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
    checks++; if (bus.out_ch !== 2'd0 || bus.out_pl !== 16'h0 || bus.out_len !== 3'd0) begin errors++; $display("FAIL reset_out_regs: got ch=%0d pl=%h len=%0d want 0", bus.out_ch, bus.out_pl, bus.out_len); end
    checks++; if (bus.ch_busy !== 4'h0) begin errors++; $display("FAIL reset_busy: got %b want 0000", bus.ch_busy); end
    checks++; if (bus.err_cnt !== 16'h0) begin errors++; $display("FAIL reset_err: got %h want 0", bus.err_cnt); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
  endtask

  task automatic test_basic();
    bus.out_ready = 1'b1;
    send(1, 8'hA5); send(1, 8'h03); send(1, 8'h04); send(1, 8'h00);
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL basic_latency_early: got out_valid=%b want 0", bus.out_valid); end
    @(negedge clock);
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL basic_latency: got out_valid=%b want 1", bus.out_valid); end
    checks++; if (bus.out_ch !== 2'd1 || bus.out_pl !== 16'h0007 || bus.out_len !== 3'd2) begin errors++; $display("FAIL basic_payload: got ch=%0d pl=%h len=%0d want ch=1 pl=0007 len=2", bus.out_ch, bus.out_pl, bus.out_len); end
  endtask

  task automatic test_maxlen();
    send(0, 8'hA5);
    repeat (4) send(0, 8'hFF);
    bus.in_ch = 2'd0;
    #1;
    checks++; if (bus.in_ready !== 1'b0 || bus.ch_busy[0] !== 1'b1) begin errors++; $display("FAIL maxlen_emit: got in_ready=%b busy0=%b want 0,1", bus.in_ready, bus.ch_busy[0]); end
    @(negedge clock);
    checks++; if (bus.out_valid !== 1'b1 || bus.out_ch !== 2'd0 || bus.out_pl !== 16'h03FC || bus.out_len !== 3'd4) begin errors++; $display("FAIL maxlen_payload: got v=%b ch=%0d pl=%h len=%0d want 1,0,03FC,4", bus.out_valid, bus.out_ch, bus.out_pl, bus.out_len); end
    send(0, 8'h12);
    checks++; if (bus.err_cnt !== 16'd1) begin errors++; $display("FAIL maxlen_drop_err: got %0d want 1", bus.err_cnt); end
  endtask

  task automatic test_arbitration();
    bus.out_ready = 1'b0;
    send(0, 8'hA5); send(0, 8'h10); send(0, 8'h00);
    for (int c = 1; c < 4; c++) begin
      send(c, 8'hA5); send(c, 8'(c)); send(c, 8'h00);
    end
    for (int t = 0; t < 5; t++) begin
      checks++; if (bus.out_valid !== 1'b1 || bus.out_ch !== 2'd0 || bus.out_pl !== 16'h0010 || bus.out_len !== 3'd1) begin errors++; $display("FAIL arb_hold: cycle %0d got v=%b ch=%0d pl=%h len=%0d want 1,0,0010,1", t, bus.out_valid, bus.out_ch, bus.out_pl, bus.out_len); end
      for (int c = 1; c < 4; c++) begin
        bus.in_ch = 2'(c);
        #1;
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL arb_backpressure: ch%0d got in_ready=%b want 0", c, bus.in_ready); end
      end
      @(negedge clock);
    end
    bus.out_ready = 1'b1;
    for (int c = 1; c < 4; c++) begin
      @(negedge clock);
      checks++; if (bus.out_valid !== 1'b1 || bus.out_ch !== 2'(c) || bus.out_pl !== 16'(c) || bus.out_len !== 3'd1) begin errors++; $display("FAIL arb_order: got v=%b ch=%0d pl=%h len=%0d want 1,%0d,%h,1", bus.out_valid, bus.out_ch, bus.out_pl, bus.out_len, c, c); end
    end
    @(negedge clock);
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL arb_drain: got out_valid=%b want 0", bus.out_valid); end
  endtask

  task automatic test_wrap();
    bus8.out_ready = 1'b1;
    send8(2, 8'hA5); send8(2, 8'h80); send8(2, 8'h90); send8(2, 8'h00);
    @(negedge clock);
    checks++; if (bus8.out_valid !== 1'b1 || bus8.out_ch !== 2'd2 || bus8.out_pl !== 8'h10 || bus8.out_len !== 3'd2) begin errors++; $display("FAIL wrap_payload: got v=%b ch=%0d pl=%h len=%0d want 1,2,10,2", bus8.out_valid, bus8.out_ch, bus8.out_pl, bus8.out_len); end
  endtask

  task automatic test_random();
    int r, ch, g, bad;
    logic v, ordy, exp_rdy;
    logic [7:0] code;
    logic [3:0] exp_busy;
    do_reset();
    for (int c = 0; c < 4; c++) begin m_mode[c] = 0; m_sum[c] = 0; m_n[c] = 0; end
    m_ov = 0; m_ch = 0; m_pl = 0; m_len = 0; m_last = 3; m_err = 0;
    bad = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      r = $urandom_range(0, 9);
      code = r < 3 ? 8'hA5 : r < 5 ? 8'h00 : 8'($urandom_range(1, 255));
      ch = $urandom_range(0, 3);
      v = $urandom_range(0, 9) < 8;
      ordy = $urandom_range(0, 9) < 7;
      bus.in_valid = v; bus.in_ch = 2'(ch); bus.in_code = code; bus.out_ready = ordy;
      #1;
      exp_rdy = m_mode[ch] != 2;
      for (int c = 0; c < 4; c++) exp_busy[c] = m_mode[c] != 0;
      checks++;
      if (bus.in_ready !== exp_rdy || bus.out_valid !== 1'(m_ov) || bus.out_ch !== 2'(m_ch) || bus.out_pl !== 16'(m_pl) ||
          bus.out_len !== 3'(m_len) || bus.ch_busy !== exp_busy || bus.err_cnt !== 16'(m_err)) begin
        errors++;
        if (bad++ < 5) $display("FAIL random cyc %0d: got rdy=%b v=%b ch=%0d pl=%h len=%0d busy=%b err=%0d want rdy=%b v=%0d ch=%0d pl=%h len=%0d busy=%b err=%0d",
          cyc, bus.in_ready, bus.out_valid, bus.out_ch, bus.out_pl, bus.out_len, bus.ch_busy, bus.err_cnt,
          exp_rdy, m_ov, m_ch, m_pl, m_len, exp_busy, m_err);
      end
      if (m_ov == 0 || ordy) begin
        g = -1;
        for (int k = 1; k <= 4; k++) if (g < 0 && m_mode[(m_last + k) % 4] == 2) g = (m_last + k) % 4;
        if (g >= 0) begin
          m_ov = 1; m_ch = g; m_pl = m_sum[g]; m_len = m_n[g]; m_last = g; m_mode[g] = 0;
        end else m_ov = 0;
      end
      if (v && exp_rdy) begin
        if (m_mode[ch] == 0) begin
          if (code == 8'hA5) begin m_mode[ch] = 1; m_sum[ch] = 0; m_n[ch] = 0; end
          else if (m_err < 65535) m_err++;
        end else if (code == 0) m_mode[ch] = 2;
        else begin
          m_sum[ch] = (m_sum[ch] + int'(code)) % 65536;
          m_n[ch]++;
          if (m_n[ch] == 4) m_mode[ch] = 2;
        end
      end
      @(negedge clock);
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    bus.out_ready = 1'b0;
    send(0, 8'hA5); send(0, 8'h01); send(0, 8'h00);
    send(3, 8'hA5); send(3, 8'h05);
    @(negedge clock);
    checks++; if (bus.out_valid !== 1'b1 || bus.ch_busy[3] !== 1'b1) begin errors++; $display("FAIL rstmid_setup: got v=%b busy3=%b want 1,1", bus.out_valid, bus.ch_busy[3]); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (bus.out_valid !== 1'b0 || bus.out_ch !== 2'd0 || bus.out_pl !== 16'h0 || bus.out_len !== 3'd0) begin errors++; $display("FAIL rstmid_out: got v=%b ch=%0d pl=%h len=%0d want 0", bus.out_valid, bus.out_ch, bus.out_pl, bus.out_len); end
    checks++; if (bus.ch_busy !== 4'h0 || bus.err_cnt !== 16'h0) begin errors++; $display("FAIL rstmid_status: got busy=%b err=%0d want 0", bus.ch_busy, bus.err_cnt); end
    @(negedge clock);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    send(3, 8'hA5); send(3, 8'h01); send(3, 8'h00);
    @(negedge clock);
    checks++; if (bus.out_valid !== 1'b1 || bus.out_ch !== 2'd3 || bus.out_pl !== 16'h0001 || bus.out_len !== 3'd1) begin errors++; $display("FAIL rstmid_after: got v=%b ch=%0d pl=%h len=%0d want 1,3,0001,1", bus.out_valid, bus.out_ch, bus.out_pl, bus.out_len); end
  endtask

  task automatic test_saturate();
    do_reset();
    bus.in_valid = 1'b1; bus.in_ch = 2'd0; bus.in_code = 8'h12;
    repeat (1000) @(negedge clock);
    checks++; if (bus.err_cnt !== 16'd1000) begin errors++; $display("FAIL sat_progress: got %0d want 1000", bus.err_cnt); end
    repeat (69000) @(negedge clock);
    bus.in_valid = 1'b0;
    checks++; if (bus.err_cnt !== 16'hFFFF) begin errors++; $display("FAIL sat_final: got %h want FFFF", bus.err_cnt); end
  endtask

  initial begin
    bus.match_code = 8'hA5; bus.in_valid = 1'b0; bus.in_ch = '0; bus.in_code = '0; bus.out_ready = 1'b1;
    bus8.match_code = 8'hA5; bus8.in_valid = 1'b0; bus8.in_ch = '0; bus8.in_code = '0; bus8.out_ready = 1'b1;
    test_reset();
    test_basic();
    test_maxlen();
    test_arbitration();
    test_wrap();
    test_random();
    test_reset_mid();
    test_saturate();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
